// File: rtl/h14tx_island_scheduler.sv
// HDMI data-island scheduler: places preamble, guards and round-robin packet
// slots inside horizontal blanking, one cycle behind the cursor x.
module h14tx_island_scheduler #(
  parameter int BitWidth     = 11,
  parameter int NumSources   = 4,
  parameter int IslandStartX = 1292,
  parameter int WindowEndX   = 1640,
  parameter int MaxPackets   = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BitWidth-1:0]           x,
  input  logic [NumSources-1:0]         req,
  output logic [NumSources-1:0]         grant,
  output logic [$clog2(NumSources)-1:0] src_sel,
  output logic [4:0]                    pkt_clk,
  output logic [2:0]                    phase,
  output logic                          busy
);

  localparam int SelW = $clog2(NumSources);
  localparam int NpkW = $clog2(MaxPackets + 1);
  localparam logic [BitWidth-1:0] StartX = BitWidth'(IslandStartX);
  localparam logic [NpkW-1:0] MaxNpk = NpkW'(MaxPackets);

  if (IslandStartX + 8 + 2 + 32 + 2 > WindowEndX) begin : g_chk_window
    $error("island does not fit between IslandStartX and WindowEndX");
  end
  if (NumSources < 2) begin : g_chk_sources
    $error("NumSources must be at least 2");
  end
  if (MaxPackets < 1 || MaxPackets > 18) begin : g_chk_packets
    $error("MaxPackets must be in 1..18");
  end

  // Encoding doubles as the phase output value.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PREAMBLE = 3'd1,
    LGUARD   = 3'd2,
    PACKET   = 3'd3,
    TGUARD   = 3'd4
  } state_t;

  state_t                r_state, w_state_next;
  logic [5:0]            r_cnt, w_cnt_next;
  logic [4:0]            r_pkt_clk, w_pkt_next;
  logic [NpkW-1:0]       r_npk, w_npk_next;
  logic [NumSources-1:0] r_grant, w_grant_next;
  logic [SelW-1:0]       r_src_sel, w_sel_next;
  logic [SelW-1:0]       r_ptr, w_ptr_next;
  logic                  r_real, w_real_next;
  logic                  r_busy;

  logic [NumSources-1:0] w_mask, w_cand;
  logic                  w_found;
  logic [SelW-1:0]       w_win;
  logic                  w_fits;
  logic                  w_arb;

  // The slot just granted goes to the back of the line for a continuation.
  always_comb begin
    w_mask = '0;
    if (r_state == PACKET && r_real) begin
      w_mask = NumSources'(1) << r_src_sel;
    end
    w_cand  = req & ~w_mask;
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int i = 1; i <= NumSources; i++) begin
      if (!w_found && w_cand[SelW'((int'(r_ptr) + i) % NumSources)]) begin
        w_found = 1'b1;
        w_win   = SelW'((int'(r_ptr) + i) % NumSources);
      end
    end
  end

  // x here is the first pixel of the would-be next slot; slot plus trailing guard must fit.
  assign w_fits = (32'(x) + 32'd34) <= 32'(WindowEndX);

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_pkt_next   = r_pkt_clk;
    w_npk_next   = r_npk;
    w_grant_next = '0;
    w_sel_next   = r_src_sel;
    w_ptr_next   = r_ptr;
    w_real_next  = r_real;
    w_arb        = 1'b0;
    case (r_state)
      IDLE: begin
        if (x == StartX && |req) begin
          w_state_next = PREAMBLE;
          w_cnt_next   = 6'd7;
          w_npk_next   = '0;
          w_pkt_next   = '0;
        end
      end
      PREAMBLE: begin
        if (r_cnt == 6'd0) begin
          w_state_next = LGUARD;
          w_cnt_next   = 6'd1;
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      LGUARD: begin
        if (r_cnt == 6'd0) begin
          w_state_next = PACKET;
          w_arb        = 1'b1;
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      PACKET: begin
        if (r_pkt_clk == 5'd31) begin
          if (w_found && r_npk < MaxNpk && w_fits) begin
            w_arb = 1'b1;
          end else begin
            w_state_next = TGUARD;
            w_cnt_next   = 6'd1;
            w_pkt_next   = '0;
          end
        end else begin
          w_pkt_next = r_pkt_clk + 5'd1;
        end
      end
      TGUARD: begin
        if (r_cnt == 6'd0) begin
          w_state_next = IDLE;
        end else begin
          w_cnt_next = r_cnt - 6'd1;
        end
      end
      default: w_state_next = IDLE;
    endcase

    // With no requester left the slot still goes out as a null packet.
    if (w_arb) begin
      w_pkt_next = '0;
      w_npk_next = r_npk + NpkW'(1);
      if (w_found) begin
        w_grant_next = NumSources'(1) << w_win;
        w_sel_next   = w_win;
        w_ptr_next   = w_win;
        w_real_next  = 1'b1;
      end else begin
        w_sel_next  = r_ptr;
        w_real_next = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_pkt_clk <= '0;
      r_npk     <= '0;
      r_grant   <= '0;
      r_src_sel <= '0;
      r_ptr     <= SelW'(NumSources - 1);
      r_real    <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_pkt_clk <= w_pkt_next;
      r_npk     <= w_npk_next;
      r_grant   <= w_grant_next;
      r_src_sel <= w_sel_next;
      r_ptr     <= w_ptr_next;
      r_real    <= w_real_next;
      r_busy    <= (w_state_next != IDLE);
    end
  end

  assign grant   = r_grant;
  assign src_sel = r_src_sel;
  assign pkt_clk = r_pkt_clk;
  assign phase   = r_state;
  assign busy    = r_busy;

endmodule

// File: doc/h14tx_island_scheduler.md
Name: h14tx_island_scheduler

Overview:
- Schedules HDMI data islands inside the horizontal blanking interval.
- Arbitrates round-robin between NumSources packet requesters (AVI/audio InfoFrame, ACR, audio sample, GCP, etc.).
- Sequences preamble, leading guard, 32-clock packet slots and trailing guard.
- Sits beside the timings top: consumes the cursor x coordinate and drives the encoder's period selection plus per-source grant and packet-clock strobes.

Parameters:
- BitWidth, 11, width of x.
- NumSources, 4, number of packet requesters (2..8).
- IslandStartX, 1292, x at which an island may begin (ActiveWidth + control margin).
- WindowEndX, 1640, last x at which an island clock may be emitted (must keep ≥4 clocks of control before active video).
- MaxPackets, 2, maximum packets per island (1..18).

Ports:
- clk  input  1  pixel clock.
- rst  input  1  reset; asynchronous, active-high.
- x  input  BitWidth  cursor column from the timing cursor.
- req  input  NumSources  level request per source; held until granted.
- grant  output  NumSources  one-hot, one-cycle pulse on the first clock of the granted packet.
- src_sel  output  $clog2(NumSources)  index of the source owning the current packet slot, held for all 32 clocks.
- pkt_clk  output  5  clock index within the packet slot, 0..31.
- phase  output  3  0=CONTROL, 1=PREAMBLE, 2=LEAD_GUARD, 3=PACKET, 4=TRAIL_GUARD.
- busy  output  1  high whenever phase != CONTROL.

Behaviour:
- Reset: all outputs 0; FSM in IDLE; round-robin pointer at NumSources-1, so the first search starts at source 0.
- All outputs are registered. Outputs describe pixel x-1 (one-cycle latency); the pixel/encoder path delays x-aligned data by one cycle.
- FSM states: IDLE, PREAMBLE, LGUARD, PACKET, TGUARD. Down-counter cnt is 6 bits; packet count npk ranges 0..MaxPackets.
- IDLE → PREAMBLE: when x == IslandStartX and |req. Load cnt = 7; phase = PREAMBLE for 8 clocks.
  - If req is all-zero at x == IslandStartX, no island is sent on that line; there is no retry later in the line.
- PREAMBLE → LGUARD after 8 clocks: 2 clocks.
- LGUARD → PACKET:
  - Arbitrate on the final LGUARD clock. Round-robin search starts at pointer+1; the first asserted req wins; pointer is updated to the winner.
  - On the first PACKET clock: src_sel = winner, grant[winner] = 1 for exactly one cycle, pkt_clk = 0, npk = 1.
  - If all requests dropped during preamble/guard, substitute a null slot: src_sel = pointer, grant = 0. The slot is still sent; the encoder emits a null packet.
- PACKET: pkt_clk increments 0..31.
  - On pkt_clk == 31, continue to another PACKET when all of the following hold:
    - |req, considering sources other than the one just granted first (round-robin);
    - npk < MaxPackets;
    - x + 34 <= WindowEndX.
  - When continuing: arbitrate as above, npk increments, pkt_clk wraps to 0. Otherwise go to TGUARD.
- TGUARD: 2 clocks, then IDLE with phase = CONTROL.
- Requests:
  - Deassertion of req mid-packet has no effect; the slot completes.
  - req of the currently granted source sampled on the same cycle as its grant is treated as consumed.
  - A source re-asserting for a second packet becomes eligible at the next arbitration.
- Compile-time checks (elaborate error on violation):
  - IslandStartX + 8 + 2 + 32 + 2 <= WindowEndX;
  - NumSources >= 2;
  - 1 <= MaxPackets <= 18.
- x wrap (FrameWidth-1 → 0) while not IDLE cannot occur under the checks above. If it does (bad parameters), the FSM completes its sequence regardless of x.
- Asynchronous reset mid-island: immediate return to IDLE/CONTROL, grant = 0, pointer reset. No partial trailing guard is emitted.

Test Plan:
- Defaults, req=4'b0001 held at x=1292: phase=1 for x=1292..1299 (outputs one cycle later), 2 for 2 clocks, 3 for 32 clocks with grant=0001 pulsed at pkt_clk=0, then 4 for 2 clocks, then 0. Next line repeats.
- Fairness: req=4'b1111 continuously, MaxPackets=2.
  - Line 1: packets to src 0, then 1.
  - Line 2: packets to src 2, then 3.
  - Line 3: packets to src 0, then 1.
  - No source is granted twice per island.
- Fit limit: MaxPackets=18, WindowEndX=1420, req=1111: island stops after the last packet with x+34<=1420. Expect 3 packets, then TGUARD.
- Request drop: req=0010 at x=1292, dropped during PREAMBLE → one PACKET slot with grant=0, src_sel=pointer. Island length is still 44 clocks.
- No request at x=1292, req asserted at x=1300 → no island that line; island starts at x=1292 of the next line.
- Assert rst during pkt_clk=10 → phase=0, grant=0, busy=0 in the same cycle. After release, the first grant goes to src 0.
